// File: rtl/step_dir_decoder.sv
// step_dir_decoder: rebuilds microstep position and turns from step/dir pins, with window rate and timing checks
module step_dir_decoder #(
  parameter int stepsPerRev    = 3200,
  parameter int minHighCycles  = 100,
  parameter int dirSetupCycles = 50,
  parameter int windowCycles   = 500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step,
  input  logic        dir,
  input  logic        clear_pos,
  input  logic        err_clr,
  output logic [11:0] position,
  output logic [15:0] turns,
  output logic [15:0] steps_in_window,
  output logic        window_valid,
  output logic        err_width,
  output logic        err_setup
);
  localparam int WW = $clog2(minHighCycles + 1);
  localparam int SW = $clog2(dirSetupCycles + 1);
  localparam int CW = $clog2(windowCycles);
  typedef enum logic {IDLE, HIGH} state_t;
  state_t state;
  logic step_s1, step_s2, step_s3, dir_s1, dir_s2, dir_s3;
  logic ev, dir_chg, w_viol, s_viol, win_last;
  logic [WW-1:0] wcnt;
  logic [SW-1:0] scnt;
  logic [CW-1:0] wincnt;
  logic signed [15:0] acc, acc_next;
  logic signed [16:0] delta, sum;
  assign ev       = step_s2 & ~step_s3;
  assign dir_chg  = dir_s2 ^ dir_s3;
  assign w_viol   = (state == HIGH) && !step_s2 && (wcnt < WW'(minHighCycles - 1));
  assign s_viol   = (ev && (scnt < SW'(dirSetupCycles))) || (dir_chg && (state == HIGH));
  assign win_last = wincnt == CW'(windowCycles - 1);
  // net step contribution this cycle, saturated into the 16-bit accumulator
  always_comb begin
    delta    = ev ? (dir_s2 ? 17'sd1 : -17'sd1) : 17'sd0;
    sum      = acc + delta;
    acc_next = (sum[16] != sum[15]) ? (sum[16] ? 16'sh8000 : 16'sh7fff) : sum[15:0];
  end
  // two-flop synchronizers plus a third step flop for rising-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {step_s3, step_s2, step_s1} <= '0;
      {dir_s3, dir_s2, dir_s1}    <= '0;
    end else begin
      {step_s3, step_s2, step_s1} <= {step_s2, step_s1, step};
      {dir_s3, dir_s2, dir_s1}    <= {dir_s2, dir_s1, dir};
    end
  end
  // high-width FSM; the event cycle counts as the first high cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      err_width <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (ev) begin
          state <= HIGH;
          wcnt  <= '0;
        end
      end else if (step_s2) wcnt <= (wcnt == WW'(minHighCycles)) ? wcnt : wcnt + 1'b1;
      else state <= IDLE;
      err_width <= w_viol | (err_width & ~err_clr);
    end
  end
  // dir stability counter and sticky setup/hold flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scnt      <= '0;
      err_setup <= 1'b0;
    end else begin
      scnt      <= dir_chg ? '0 : (scnt == SW'(dirSetupCycles)) ? scnt : scnt + 1'b1;
      err_setup <= s_viol | (err_setup & ~err_clr);
    end
  end
  // absolute position with revolution wrap; clear wins over a same-cycle event
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      position <= '0;
      turns    <= '0;
    end else if (clear_pos) begin
      position <= '0;
      turns    <= '0;
    end else if (ev && dir_s2) begin
      position <= (position == 12'(stepsPerRev - 1)) ? 12'd0 : position + 12'd1;
      turns    <= (position == 12'(stepsPerRev - 1)) ? turns + 16'd1 : turns;
    end else if (ev) begin
      position <= (position == 12'd0) ? 12'(stepsPerRev - 1) : position - 12'd1;
      turns    <= (position == 12'd0) ? turns - 16'd1 : turns;
    end
  end
  // measurement window: publish the accumulated net steps at terminal count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wincnt          <= '0;
      acc             <= '0;
      steps_in_window <= '0;
      window_valid    <= 1'b0;
    end else begin
      wincnt          <= win_last ? '0 : wincnt + 1'b1;
      acc             <= win_last ? 16'sd0 : acc_next;
      steps_in_window <= win_last ? acc_next : steps_in_window;
      window_valid    <= win_last;
    end
  end
endmodule

// File: tb/tb_step_dir_decoder.sv
// tb_step_dir_decoder: directed and randomized pulse trains checked against an integer position model
module tb_step_dir_decoder;
  localparam int SPR = 3200;
  localparam int MH  = 4;
  localparam int DS  = 6;
  localparam int W   = 1000;
  logic clock = 1'b0, reset = 1'b0, step = 1'b0, dir = 1'b0, clear_pos = 1'b0, err_clr = 1'b0;
  logic [11:0] position;
  logic [15:0] turns, steps_in_window;
  logic window_valid, err_width, err_setup;
  int cyc, since_dir, total, win_sum, pass_n, total_n;
  logic w_err, s_err;

  step_dir_decoder #(.stepsPerRev(SPR), .minHighCycles(MH), .dirSetupCycles(DS), .windowCycles(W)) dut (
    .clock(clock), .reset(reset), .step(step), .dir(dir), .clear_pos(clear_pos), .err_clr(err_clr),
    .position(position), .turns(turns), .steps_in_window(steps_in_window), .window_valid(window_valid),
    .err_width(err_width), .err_setup(err_setup)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      cyc++;
      since_dir++;
    end
  endtask

  task automatic tog();
    dir = ~dir;
    since_dir = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step = 1'b0;
    clear_pos = 1'b0;
    err_clr = 1'b0;
    tick(2);
    reset = 1'b1;
    cyc = 0;
    since_dir = dir ? 0 : 1000;
    total = 0;
    win_sum = 0;
    w_err = 1'b0;
    s_err = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo, input int m);
    if (since_dir < DS) s_err = 1'b1;
    if (hi < MH) w_err = 1'b1;
    total += dir ? 1 : -1;
    win_sum += dir ? 1 : -1;
    step = 1'b1;
    if (m > 0) begin
      tick(m);
      tog();
      s_err = 1'b1;
      tick(hi - m);
    end else tick(hi);
    step = 1'b0;
    tick(lo);
  endtask

  task automatic clr_errs();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    w_err = 1'b0;
    s_err = 1'b0;
  endtask

  task automatic clr_pos();
    clear_pos = 1'b1;
    tick(1);
    clear_pos = 1'b0;
    total = 0;
  endtask

  task automatic check_model(input string tag);
    int p, t;
    logic [15:0] tt;
    p = total % SPR;
    if (p < 0) p += SPR;
    t = (total - p) / SPR;
    tt = t[15:0];
    chk({tag, ".position"}, position, p);
    chk({tag, ".turns"}, turns, tt);
    chk({tag, ".err_width"}, err_width, w_err);
    chk({tag, ".err_setup"}, err_setup, s_err);
  endtask

  initial begin
    int hi, m, kind;
    pass_n = 0;
    total_n = 0;
    dir = 1'b1;
    do_reset();
    #1;
    chk("rst.position", position, 0);
    chk("rst.turns", turns, 0);
    chk("rst.steps_in_window", steps_in_window, 0);
    chk("rst.window_valid", window_valid, 0);
    chk("rst.err_width", err_width, 0);
    chk("rst.err_setup", err_setup, 0);

    // window: 7 forward, 2 reverse, the last reverse coincident with clear_pos
    tick(2 * DS);
    repeat (7) pulse(MH, MH, 0);
    tog();
    tick(2 * DS);
    pulse(MH, MH, 0);
    check_model("win_pre");
    win_sum += dir ? 1 : -1;
    step = 1'b1;
    tick(2);
    clear_pos = 1'b1;
    tick(1);
    clear_pos = 1'b0;
    total = 0;
    tick(MH - 3);
    step = 1'b0;
    tick(MH);
    check_model("win_coincident_clear");
    tick(W - 1 - cyc);
    chk("win1.valid_before", window_valid, 0);
    tick(1);
    chk("win1.valid", window_valid, 1);
    chk("win1.steps", steps_in_window, win_sum);
    win_sum = 0;
    tick(1);
    chk("win1.valid_after", window_valid, 0);
    tick(2 * W - 1 - cyc);
    chk("win2.valid_before", window_valid, 0);
    tick(1);
    chk("win2.valid", window_valid, 1);
    chk("win2.steps", steps_in_window, win_sum);

    // reverse wrap from zero, then clear
    dir = 1'b0;
    do_reset();
    tick(2 * DS);
    pulse(MH, MH, 0);
    check_model("rev_wrap");
    clr_pos();
    check_model("rev_clear");

    // forward count across one full revolution
    dir = 1'b1;
    do_reset();
    tick(100);
    repeat (3201) pulse(MH, MH, 0);
    check_model("fwd_count");

    // width violation, clear, then a minimum legal width
    tick(2 * DS + 2);
    pulse(MH / 2, 2 * DS + 2, 0);
    check_model("width_short");
    clr_errs();
    check_model("width_cleared");
    pulse(MH, 2 * DS + 2, 0);
    check_model("width_legal");

    // setup violation on a reverse step, then a dir change mid-high
    tog();
    tick(2);
    pulse(MH, 2 * DS + 2, 0);
    check_model("setup_short");
    clr_errs();
    check_model("setup_cleared");
    pulse(2 * MH, 2 * DS + 2, 3);
    check_model("hold_midhigh");
    clr_errs();

    // randomized pulse trains against the model
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        tog();
        tick($urandom_range(1, DS - 2));
      end else if (kind == 1) begin
        tog();
        tick($urandom_range(DS + 2, 2 * DS));
      end
      hi = $urandom_range(0, 1) ? $urandom_range(MH, 2 * MH) : $urandom_range(1, MH - 2);
      m = (hi >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, hi - 1) : 0;
      pulse(hi, $urandom_range(2 * DS + 2, 3 * DS), m);
      check_model("rand");
      if (i % 8 == 3) clr_errs();
      if (i % 16 == 11) clr_pos();
    end

    // asynchronous reset while step is high
    step = 1'b1;
    tick(3);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid.position", position, 0);
    chk("rst_mid.turns", turns, 0);
    chk("rst_mid.steps_in_window", steps_in_window, 0);
    chk("rst_mid.window_valid", window_valid, 0);
    chk("rst_mid.err_width", err_width, 0);
    chk("rst_mid.err_setup", err_setup, 0);
    step = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
